// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches two-byte instructions, gathers the data-memory
// operand and strobes the ALU. STORE, branches and HALT are executed here.
//
//  state    | meaning
//  S_FETCH  | idle; start fetching at PC when run is high
//  S_OPC    | opcode byte arriving from program memory
//  S_OPND   | operand byte arriving; dispatch on opcode class
//  S_MREAD  | data-memory read issued at IBR
//  S_MCAP   | data-memory read data captured into MBR
//  S_EXEC   | one-cycle ALU execute strobe
//  S_STORE  | one-cycle write of AR to dmem[IBR]
//  S_HALT   | stopped; only arst leaves this state

`ifndef CARRY
`define CARRY 0
`endif
`ifndef OV
`define OV 1
`endif
`ifndef ZERO
`define ZERO 2
`endif
`ifndef NEG
`define NEG 3
`endif

module fetch_sequencer #(
    parameter int WIDTH    = 8,
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                run,
    output logic [PC_WIDTH-1:0] pmem_addr,
    input  logic [WIDTH-1:0]    pmem_data,
    output logic [WIDTH-1:0]    dmem_addr,
    output logic                dmem_re,
    input  logic [WIDTH-1:0]    dmem_rdata,
    output logic                dmem_we,
    output logic [WIDTH-1:0]    dmem_wdata,
    input  logic [WIDTH-1:0]    AR,
    input  logic [3:0]          Flags,
    output logic [WIDTH-1:0]    IR,
    output logic [WIDTH-1:0]    IBR,
    output logic [WIDTH-1:0]    MBR,
    output logic                Exec,
    output logic [PC_WIDTH-1:0] PC,
    output logic                halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_OPC,
        S_OPND,
        S_MREAD,
        S_MCAP,
        S_EXEC,
        S_STORE,
        S_HALT
    } state_t;

    state_t state;
    logic   branch_taken;

    // Branch condition from the latched opcode and the ALU flags seen in S_OPND
    always_comb begin
        branch_taken = 1'b0;
        case (IR[2:0])
            3'd0:    branch_taken = 1'b1;
            3'd1:    branch_taken = Flags[`ZERO];
            3'd2:    branch_taken = ~Flags[`ZERO];
            3'd3:    branch_taken = Flags[`CARRY];
            3'd4:    branch_taken = ~Flags[`CARRY];
            3'd5:    branch_taken = Flags[`NEG];
            3'd6:    branch_taken = Flags[`OV];
            default: branch_taken = 1'b0;
        endcase
    end

    // Sequencer state, program counter and ALU-facing registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= S_FETCH;
            PC    <= '0;
            IR    <= '0;
            IBR   <= '0;
            MBR   <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (run) begin
                        PC    <= PC + PC_WIDTH'(1);
                        state <= S_OPC;
                    end
                end
                S_OPC: begin
                    IR    <= pmem_data;
                    PC    <= PC + PC_WIDTH'(1);
                    state <= S_OPND;
                end
                S_OPND: begin
                    IBR <= pmem_data;
                    if (!IR[7]) begin
                        state <= S_MREAD;
                    end else if (!IR[6]) begin
                        state <= S_STORE;
                    end else if (IR[2:0] == 3'b111) begin
                        state <= S_HALT;
                    end else begin
                        if (branch_taken) begin
                            PC <= PC_WIDTH'(pmem_data);
                        end
                        state <= S_FETCH;
                    end
                end
                S_MREAD: state <= S_MCAP;
                S_MCAP: begin
                    MBR   <= dmem_rdata;
                    state <= S_EXEC;
                end
                S_EXEC:  state <= S_FETCH;
                S_STORE: state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Strobes decode straight from the state register so arst kills them at once
    assign Exec       = (state == S_EXEC);
    assign dmem_re    = (state == S_MREAD);
    assign dmem_we    = (state == S_STORE);
    assign halted     = (state == S_HALT);
    assign pmem_addr  = PC;
    assign dmem_addr  = IBR;
    assign dmem_wdata = AR;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed corner cases, a branch-condition table
// and a random program checked against an instruction-level reference model.
`timescale 1ns/1ps

`ifndef CARRY
`define CARRY 0
`endif
`ifndef OV
`define OV 1
`endif
`ifndef ZERO
`define ZERO 2
`endif
`ifndef NEG
`define NEG 3
`endif

module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       arst, run;
    logic [7:0] pmem_addr, pmem_data, dmem_addr, dmem_rdata, dmem_wdata;
    logic [7:0] AR, IR, IBR, MBR, PC;
    logic       dmem_re, dmem_we, Exec, halted;
    logic [3:0] Flags;

    logic [7:0] pmem [256];
    logic [7:0] dmem [256];
    logic       poke_en;
    logic [7:0] poke_addr, poke_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_pc, m_ir, m_ibr, m_mbr;
    logic [7:0] m_dmem [256];

    localparam logic [3:0] FC = 4'b1 << `CARRY;
    localparam logic [3:0] FV = 4'b1 << `OV;
    localparam logic [3:0] FZ = 4'b1 << `ZERO;
    localparam logic [3:0] FN = 4'b1 << `NEG;

    typedef struct {
        logic [7:0] op;
        logic [3:0] flags;
        logic [7:0] exp_pc;
    } br_vec_t;

    br_vec_t br_tab [15];

    fetch_sequencer dut (
        .clk        (clk),
        .arst       (arst),
        .run        (run),
        .pmem_addr  (pmem_addr),
        .pmem_data  (pmem_data),
        .dmem_addr  (dmem_addr),
        .dmem_re    (dmem_re),
        .dmem_rdata (dmem_rdata),
        .dmem_we    (dmem_we),
        .dmem_wdata (dmem_wdata),
        .AR         (AR),
        .Flags      (Flags),
        .IR         (IR),
        .IBR        (IBR),
        .MBR        (MBR),
        .Exec       (Exec),
        .PC         (PC),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Synchronous memories with one-cycle read latency
    always @(posedge clk) begin
        pmem_data  <= pmem[pmem_addr];
        dmem_rdata <= dmem[dmem_addr];
        if (poke_en)      dmem[poke_addr] = poke_data;
        else if (dmem_we) dmem[dmem_addr] = dmem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cond_ok(input logic [2:0] c, input logic [3:0] f);
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return f[`ZERO];
            3'd2:    return !f[`ZERO];
            3'd3:    return f[`CARRY];
            3'd4:    return !f[`CARRY];
            3'd5:    return f[`NEG];
            3'd6:    return f[`OV];
            default: return 1'b0;
        endcase
    endfunction

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        run  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
    endtask

    // Called at a negedge with the DUT in S_FETCH; returns at the negedge of
    // the next S_FETCH cycle. Cycle numbers count from S_FETCH as cycle 1.
    task automatic exec_instr(input int len, input int ex_c, input int re_c, input int we_c,
                              input logic [7:0] st_addr, input logic [7:0] st_data,
                              input logic keep_run, input string tag);
        run = 1'b1;
        for (int k = 1; k <= len; k++) begin
            if (k > 1) begin
                @(negedge clk);
                if (!keep_run) run = 1'b0;
            end
            check({tag, " strobes{exec,re,we}"}, {Exec, dmem_re, dmem_we},
                  {k == ex_c, k == re_c, k == we_c});
            if (k == we_c) begin
                check({tag, " dmem_addr"}, dmem_addr, st_addr);
                check({tag, " dmem_wdata"}, dmem_wdata, st_data);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] op, opnd, a1;
        bit         is_halt;

        arst = 1'b1; run = 1'b0; poke_en = 1'b0; poke_addr = 8'h0; poke_data = 8'h0;
        AR = 8'h00; Flags = 4'h0;
        for (int i = 0; i < 256; i++) pmem[i] = 8'h00;
        @(negedge clk);
        #1;
        check("reset strobes/halted", {Exec, dmem_re, dmem_we, halted}, 4'b0000);
        check("reset regs", {PC, IR, IBR, MBR}, 32'h0);

        // ALU instruction: operand from dmem[0x20]
        pmem[0] = 8'h12; pmem[1] = 8'h20;
        @(negedge clk);
        poke(8'h20, 8'h5A);
        do_reset();
        check("post-reset pmem_addr", pmem_addr, 8'h00);
        exec_instr(6, 6, 4, 0, 8'h00, 8'h00, 1'b0, "alu");
        check("alu IR", IR, 8'h12);
        check("alu IBR", IBR, 8'h20);
        check("alu MBR", MBR, 8'h5A);
        check("alu PC", PC, 8'h02);

        // run low: nothing moves
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold {strobes,PC,IR}", {Exec, dmem_re, dmem_we, PC, IR}, {3'b000, 8'h02, 8'h12});
        end

        // STORE
        pmem[0] = 8'h80; pmem[1] = 8'h41;
        do_reset();
        AR = 8'h3C;
        exec_instr(4, 0, 0, 4, 8'h41, 8'h3C, 1'b0, "store");
        check("store PC", PC, 8'h02);
        check("store IR", IR, 8'h80);
        check("store dmem[41]", dmem[8'h41], 8'h3C);

        // Branch condition table
        br_tab[0]  = '{8'hC0, 4'h0, 8'h10};
        br_tab[1]  = '{8'hC0, 4'hF, 8'h10};
        br_tab[2]  = '{8'hC1, FZ,   8'h10};
        br_tab[3]  = '{8'hC1, ~FZ,  8'h02};
        br_tab[4]  = '{8'hC2, ~FZ,  8'h10};
        br_tab[5]  = '{8'hC2, FZ,   8'h02};
        br_tab[6]  = '{8'hC3, FC,   8'h10};
        br_tab[7]  = '{8'hC3, ~FC,  8'h02};
        br_tab[8]  = '{8'hC4, ~FC,  8'h10};
        br_tab[9]  = '{8'hC4, FC,   8'h02};
        br_tab[10] = '{8'hC5, FN,   8'h10};
        br_tab[11] = '{8'hC5, ~FN,  8'h02};
        br_tab[12] = '{8'hC6, FV,   8'h10};
        br_tab[13] = '{8'hC6, ~FV,  8'h02};
        br_tab[14] = '{8'hF9, FZ,   8'h10};
        for (int i = 0; i < 15; i++) begin
            pmem[0] = br_tab[i].op; pmem[1] = 8'h10;
            do_reset();
            Flags = br_tab[i].flags;
            exec_instr(3, 0, 0, 0, 8'h00, 8'h00, 1'b0, "branch");
            check($sformatf("branch op=%0h flags=%0h next fetch", br_tab[i].op, br_tab[i].flags),
                  pmem_addr, br_tab[i].exp_pc);
            check("branch not halted", halted, 1'b0);
        end
        Flags = 4'h0;

        // HALT
        pmem[0] = 8'hC7; pmem[1] = 8'h00;
        do_reset();
        exec_instr(3, 0, 0, 0, 8'h00, 8'h00, 1'b0, "halt");
        run = 1'b1;
        check("halt flag/PC", {halted, PC}, {1'b1, 8'h02});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halted quiet {strobes,halted,PC}", {Exec, dmem_re, dmem_we, halted, PC},
                  {3'b000, 1'b1, 8'h02});
        end
        arst = 1'b1; run = 1'b0;
        #1;
        check("halt arst {halted,PC}", {halted, PC}, 9'h000);
        @(negedge clk);
        arst = 1'b0;

        // JMP 0xFE then ALU op at 0xFE/0xFF, PC wraps to 0
        pmem[0] = 8'hC0; pmem[1] = 8'hFE; pmem[8'hFE] = 8'h05; pmem[8'hFF] = 8'h33;
        @(negedge clk);
        poke(8'h33, 8'hA7);
        do_reset();
        exec_instr(3, 0, 0, 0, 8'h00, 8'h00, 1'b0, "jmp fe");
        check("jmp fe PC", PC, 8'hFE);
        exec_instr(6, 6, 4, 0, 8'h00, 8'h00, 1'b0, "wrap alu");
        check("wrap alu IR", IR, 8'h05);
        check("wrap alu IBR", IBR, 8'h33);
        check("wrap alu MBR", MBR, 8'hA7);
        check("wrap alu next fetch", pmem_addr, 8'h00);

        // JMP 0xFF: opcode at 0xFF, operand at 0x00 (wraps mid-instruction)
        pmem[1] = 8'hFF; pmem[8'hFF] = 8'h80;
        do_reset();
        AR = 8'h6E;
        exec_instr(3, 0, 0, 0, 8'h00, 8'h00, 1'b0, "jmp ff");
        check("jmp ff PC", PC, 8'hFF);
        exec_instr(4, 0, 0, 4, 8'hC0, 8'h6E, 1'b0, "wrap store");
        check("wrap store PC", PC, 8'h01);
        check("wrap store IBR", IBR, 8'hC0);

        // arst in the middle of S_STORE
        pmem[0] = 8'h80; pmem[1] = 8'h41;
        @(negedge clk);
        poke(8'h41, 8'h99);
        do_reset();
        AR = 8'h3C;
        run = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            run = 1'b0;
        end
        check("arst-store we before", dmem_we, 1'b1);
        arst = 1'b1;
        #1;
        check("arst-store strobes/halted", {Exec, dmem_re, dmem_we, halted}, 4'b0000);
        check("arst-store regs", {PC, IR, IBR, MBR}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        check("arst-store write aborted", dmem[8'h41], 8'h99);

        // Random program against the instruction-level model
        arst = 1'b1;
        for (int i = 0; i < 256; i++) pmem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) begin
            m_dmem[i] = 8'($urandom);
            poke(8'(i), m_dmem[i]);
        end
        do_reset();
        m_pc = 8'h00; m_ir = 8'h00; m_ibr = 8'h00; m_mbr = 8'h00;
        for (int n = 0; n < 300; n++) begin
            AR    = 8'($urandom);
            Flags = 4'($urandom);
            op    = pmem[m_pc];
            a1    = m_pc + 8'd1;
            opnd  = pmem[a1];
            m_pc  = m_pc + 8'd2;
            m_ir  = op;
            m_ibr = opnd;
            is_halt = 1'b0;
            if (op[7] == 1'b0) begin
                m_mbr = m_dmem[opnd];
                exec_instr(6, 6, 4, 0, 8'h00, 8'h00, 1'b1, "rnd alu");
            end else if (op[6] == 1'b0) begin
                m_dmem[opnd] = AR;
                exec_instr(4, 0, 0, 4, opnd, AR, 1'b1, "rnd store");
            end else begin
                if (op[2:0] == 3'd7) is_halt = 1'b1;
                else if (cond_ok(op[2:0], Flags)) m_pc = opnd;
                exec_instr(3, 0, 0, 0, 8'h00, 8'h00, 1'b1, "rnd branch");
            end
            check("rnd PC", PC, m_pc);
            check("rnd IR", IR, m_ir);
            check("rnd IBR", IBR, m_ibr);
            check("rnd MBR", MBR, m_mbr);
            check("rnd halted", halted, is_halt);
            if (is_halt) begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("rnd halt quiet {strobes,PC}", {Exec, dmem_re, dmem_we, PC}, {3'b000, m_pc});
                end
                do_reset();
                m_pc = 8'h00; m_ir = 8'h00; m_ibr = 8'h00; m_mbr = 8'h00;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
